serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract/negate sequencer: one 1-bit full adder cell, time-shared over WIDTH cycles, LSB first. A start/busy/done handshake sequences the operation. Serves as the area-minimal arithmetic engine beside the parallel two's-complement and ripple-adder datapaths. Results are held registered until the next accepted operation.

---
 rtl/serial_addsub_ctrl_pkg.sv | 20 ++
 rtl/serial_addsub_ctrl_if.sv | 31 +++
 rtl/serial_addsub_ctrl_full_adder.sv | 14 +
 rtl/serial_addsub_ctrl.sv | 113 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_ctrl_pkg.sv
// serial_addsub_pkg
// Shared definitions for the bit-serial add/subtract/negate sequencer:
//   op_e    : 2-bit operation encoding carried on the request bus
//   state_e : sequencer FSM states
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,   // a + b
        OP_SUB  = 2'b01,   // a - b
        OP_NEG  = 2'b10,   // -a
        OP_PASS = 2'b11    // a
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if
// Request/response bundle of the bit-serial arithmetic engine.
//   start, op, a, b        : request side, driven by the master
//   busy, done, y, cout, ovf : status/result side, driven by the engine
// Modports: master (requester), slave (engine).
interface serial_addsub_ctrl_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, y, cout, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y, cout, ovf
    );

endinterface

// File: rtl/serial_addsub_ctrl_full_adder.sv
// full_adder
// Single 1-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// Bit-serial ADD/SUB/NEG/PASS engine. One full adder cell is time-shared
// over WIDTH cycles, LSB first. An operation is accepted from IDLE on start,
// runs WIDTH cycles with busy high, then pulses done for one cycle while
// y/cout/ovf hold the new result until the next accepted operation.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_addsub_ctrl_if (start/op/a/b in,
//           busy/done/y/cout/ovf out)
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] x_q, z_q, r_q, y_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [WIDTH-1:0] x_d, z_d;
    logic             cin_d;
    logic             fa_sum, fa_cout;

    // Every op is reduced to x + z + cin so the single adder cell covers all.
    always_comb begin
        x_d   = bus.a;
        z_d   = '0;
        cin_d = 1'b0;
        case (bus.op)
            OP_ADD:  begin x_d = bus.a;  z_d = bus.b;  cin_d = 1'b0; end
            OP_SUB:  begin x_d = bus.a;  z_d = ~bus.b; cin_d = 1'b1; end
            OP_NEG:  begin x_d = ~bus.a; z_d = '0;     cin_d = 1'b1; end
            default: begin x_d = bus.a;  z_d = '0;     cin_d = 1'b0; end
        endcase
    end

    full_adder u_fa (
        .a    (x_q[0]),
        .b    (z_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            z_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        x_q     <= x_d;
                        z_q     <= z_d;
                        carry_q <= cin_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q     <= {1'b0, x_q[WIDTH-1:1]};
                    z_q     <= {1'b0, z_q[WIDTH-1:1]};
                    r_q     <= {fa_sum, r_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Processing the MSB: carry_q is the carry into it,
                        // fa_cout the carry out, so their XOR is signed overflow.
                        y_q     <= {fa_sum, r_q[WIDTH-1:1]};
                        cout_q  <= fa_cout;
                        ovf_q   <= carry_q ^ fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl
// Directed bench for serial_addsub_ctrl at WIDTH=4. Inputs are driven and
// outputs sampled on the falling clock edge; expected values are hand-computed.
module tb_serial_addsub_ctrl;
    import serial_addsub_pkg::*;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Randomise request inputs while an operation is in flight; they must not matter.
    task automatic scramble();
        bus.op = op_e'(2'($urandom_range(0, 3)));
        bus.a  = 4'($urandom_range(0, 15));
        bus.b  = 4'($urandom_range(0, 15));
    endtask

    // Called at a falling edge in IDLE; returns at a falling edge back in IDLE.
    task automatic run_op(input string tag, input op_e op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] ey,
                          input logic ec, input logic eo);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);                       // accepting edge k
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.start = 1'b0;
                scramble();
            end
            check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            check({tag, ".done_low"}, 32'(bus.done), 32'd0);
        end
        @(negedge clk);                       // cycle after edge k+WIDTH
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, ".y"}, 32'(bus.y), 32'(ey));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
        $display("op %-8s a=%b b=%b -> y=%b cout=%b ovf=%b", tag, a, b, bus.y, bus.cout, bus.ovf);
        @(negedge clk);                       // back in IDLE
        check({tag, ".done_once"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.y", 32'(bus.y), 32'd0);
        check("rst.cout", 32'(bus.cout), 32'd0);
        check("rst.ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("neg5",   OP_NEG,  4'b0101, 4'b1111, 4'b1011, 1'b0, 1'b0);
        run_op("neg8",   OP_NEG,  4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
        run_op("neg0",   OP_NEG,  4'b0000, 4'b0110, 4'b0000, 1'b1, 1'b0);
        run_op("add7p1", OP_ADD,  4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
        run_op("addFp1", OP_ADD,  4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0);
        run_op("sub2m5", OP_SUB,  4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b0);
        run_op("sub5m2", OP_SUB,  4'b0101, 4'b0010, 4'b0011, 1'b1, 1'b0);
        run_op("passF",  OP_PASS, 4'b1111, 4'b0101, 4'b1111, 1'b0, 1'b0);

        // start held high: accepts every WIDTH+2 cycles, start in DONE ignored.
        bus.start = 1'b1;
        bus.op = OP_ADD; bus.a = 4'b0011; bus.b = 4'b0010;
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("held1.busy", 32'(bus.busy), 32'd1);
            scramble();
        end
        @(negedge clk);
        check("held1.done", 32'(bus.done), 32'd1);
        check("held1.y", 32'(bus.y), 32'h5);
        $display("held op 1 ADD 0011+0010 -> y=%b", bus.y);
        bus.op = OP_SUB; bus.a = 4'b0111; bus.b = 4'b0001;
        @(negedge clk);
        check("held1.idle_busy", 32'(bus.busy), 32'd0);
        check("held1.idle_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("held2.busy", 32'(bus.busy), 32'd1);
            scramble();
        end
        @(negedge clk);
        check("held2.done", 32'(bus.done), 32'd1);
        check("held2.y", 32'(bus.y), 32'h6);
        check("held2.cout", 32'(bus.cout), 32'd1);
        $display("held op 2 SUB 0111-0001 -> y=%b cout=%b", bus.y, bus.cout);
        bus.op = OP_NEG; bus.a = 4'b0011; bus.b = 4'b1010;
        @(negedge clk);
        check("held2.idle_busy", 32'(bus.busy), 32'd0);
        check("held2.idle_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("held3.busy", 32'(bus.busy), 32'd1);
            scramble();
        end
        @(negedge clk);
        check("held3.done", 32'(bus.done), 32'd1);
        check("held3.y", 32'(bus.y), 32'hD);
        $display("held op 3 NEG 0011 -> y=%b", bus.y);
        bus.start = 1'b0;
        @(negedge clk);
        check("held3.done_once", 32'(bus.done), 32'd0);

        // Reset after two bits of an ADD: everything clears, no done follows.
        bus.start = 1'b1;
        bus.op = OP_ADD; bus.a = 4'b0110; bus.b = 4'b0101;
        @(posedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.y", 32'(bus.y), 32'd0);
        check("abort.cout", 32'(bus.cout), 32'd0);
        check("abort.ovf", 32'(bus.ovf), 32'd0);
        $display("reset asserted mid-run -> busy=%b y=%b", bus.busy, bus.y);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            check("abort.no_done", 32'(bus.done), 32'd0);
            check("abort.no_busy", 32'(bus.busy), 32'd0);
        end
        run_op("add3p4", OP_ADD, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);

        // Result held across idle cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold.y", 32'(bus.y), 32'h7);
            check("hold.done", 32'(bus.done), 32'd0);
        end
        $display("idle hold 10 cycles -> y=%b", bus.y);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
